mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 7, the maximum consecutive cycles a pending inst request may lose arbitration in fixed-priority mode.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports inst_req in 1 (fetch request), inst_addr in 32, inst_addr_ok out 1 (request accepted this cycle), inst_data_ok out 1 (read data valid), and inst_rdata out 32.
REQ-005 SHALL have ports data_req in 1, data_we in 4 (byte write enables; 0 means read), data_addr in 32, data_wdata in 32, data_addr_ok out 1, data_data_ok out 1, and data_rdata out 32.
REQ-006 SHALL have ports sram_en out 1, sram_we out 4, sram_addr out 32, sram_wdata out 32, and sram_rdata in 32 (synchronous SRAM, read data one cycle after sram_en).

Function
REQ-007 SHALL grant at most one requester per cycle; grant is combinational from req and the current state.
REQ-008 SHALL drive sram_en=1 and forward the granted requester's address, write enables and write data in the grant cycle; inst grants SHALL drive sram_we=0 and sram_wdata=0.
REQ-009 SHALL assert the granted requester's addr_ok in the grant cycle; a requester holds req and its payload stable until addr_ok.
REQ-010 SHALL assert the granted requester's data_ok exactly one cycle after the grant (fixed latency 1), and SHALL route sram_rdata to the owner's rdata in that cycle; rdata SHALL read 0 when data_ok=0.
REQ-011 SHALL assert data_data_ok for writes as well; data_rdata is then don't-care but SHALL be 0.
REQ-012 SHALL implement a response FSM with states IDLE, RESP_I and RESP_D; next state is RESP_I on an inst grant, RESP_D on a data grant, and IDLE otherwise, from any state.
REQ-013 SHALL allow a new grant in the same cycle a response is returned, sustaining one access per cycle.
REQ-014 In fixed-priority mode, SHALL grant data over inst on simultaneous requests, except when the starvation counter equals STARVE_MAX, in which case inst is granted.
REQ-015 The starvation counter (3+ bits, width ceil(log2(STARVE_MAX+1))) SHALL increment when inst_req=1 and inst loses, clear on any inst grant or when inst_req=0, and saturate at STARVE_MAX.
REQ-016 A lone requester SHALL be granted in the same cycle, with no bubble.
REQ-017 With no request, sram_en, sram_we, sram_addr and sram_wdata SHALL be 0.

Reset
REQ-018 While resetn=0: FSM=IDLE, starvation counter=0, round-robin pointer=inst, and all outputs 0 irrespective of requests.
REQ-019 Reset asserted with a response outstanding SHALL drop it; no data_ok is asserted after reset release for a pre-reset grant.
REQ-020 The first grant is possible in the first clock edge cycle after resetn rises.

Configuration
REQ-021 With macro MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted round-robin:
- a 1-bit last-grant pointer favours the requester not granted most recently;
- the pointer updates on every grant;
- the starvation counter and STARVE_MAX are unused, with the counter held at 0.
REQ-022 Without MEM_ARB_ROUND_ROBIN_EN, the fixed data-priority policy with starvation guard (REQ-014/015) SHALL apply.

Verification
REQ-023 Lone inst read:
- stimulus: inst_req=1, inst_addr=0x1C000000, sram returns 0x02800C0C;
- response: inst_addr_ok=1 in cycle 0, sram_we=0; inst_data_ok=1 and inst_rdata=0x02800C0C in cycle 1.
REQ-024 Data write:
- stimulus: data_req=1, data_we=0xF, data_addr=0x1000, data_wdata=0xDEADBEEF;
- response: sram_we=0xF and sram_wdata=0xDEADBEEF in cycle 0; data_data_ok=1 and data_rdata=0 in cycle 1.
REQ-025 Contention, fixed mode, STARVE_MAX=7:
- stimulus: both requesting continuously;
- response: data wins 7 cycles, inst granted on cycle 8, counter returns to 0.
REQ-026 Contention, MEM_ARB_ROUND_ROBIN_EN defined:
- stimulus: both requesting continuously from reset;
- response: grants alternate I,D,I,D; each data_ok follows its grant by exactly 1 cycle.
REQ-027 Back-to-back:
- stimulus: inst reads to 0x0, 0x4, 0x8 on consecutive cycles;
- response: three consecutive addr_ok, then three consecutive data_ok with matching data, FSM RESP_I throughout.
REQ-028 Reset mid-operation:
- stimulus: resetn=0 asynchronously in the cycle after a data grant;
- response: data_data_ok=0 immediately and stays 0 after release; FSM=IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-port (inst fetch / data load-store) arbiter in front of a
//                single synchronous SRAM. At most one request is granted per
//                cycle. The grant is combinational, so a lone requester is
//                served with no bubble. Read data comes back with a fixed
//                latency of one cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration:
//    MEM_ARB_ROUND_ROBIN_EN (macro) - defined  : round-robin on contention
//                                     undefined: data has priority, with a
//                                                starvation guard for inst
//    STARVE_MAX (parameter)          - most consecutive lost cycles for a
//                                     pending inst request (fixed mode)
//  Ports:
//    clk, resetn                     - clock, async active-low reset
//    inst_req/addr                   - fetch request and address
//    inst_addr_ok/data_ok/rdata      - accept strobe, response strobe, data
//    data_req/we/addr/wdata          - load/store request (we=0 is a read)
//    data_addr_ok/data_ok/rdata      - accept strobe, response strobe, data
//    sram_en/we/addr/wdata/rdata     - synchronous SRAM port
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_MAX = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESP_I = 2'd1;
    localparam logic [1:0] RESP_D = 2'd2;

    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]       state_q, state_d;
    logic             wr_q, wr_d;        // outstanding data access is a write
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             grant_i, grant_d;
    logic             inst_wins;         // tie-break result on contention

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer names the requester favoured on the next contention; it
    // always points away from whoever was granted last.
    localparam logic PTR_INST = 1'b0;
    localparam logic PTR_DATA = 1'b1;

    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        inst_wins = (rr_ptr_q == PTR_INST);
        rr_ptr_d  = rr_ptr_q;
        if (grant_i) begin
            rr_ptr_d = PTR_DATA;
        end else if (grant_d) begin
            rr_ptr_d = PTR_INST;
        end
        starve_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q <= PTR_INST;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Data normally wins; inst takes the slot once it has lost STARVE_MAX
    // cycles in a row. The counter only tracks an inst request that is
    // actually waiting, so it clears whenever inst_req drops.
    always_comb begin
        inst_wins = (starve_q == STARVE_LIM);
        starve_d  = starve_q;
        if (!inst_req || grant_i) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end
`endif

    // Grants are qualified by resetn so that every output is quiet for the
    // whole time reset is held, regardless of incoming requests.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (resetn) begin
            if (inst_req && data_req) begin
                grant_i = inst_wins;
                grant_d = !inst_wins;
            end else begin
                grant_i = inst_req;
                grant_d = data_req;
            end
        end
    end

    // The response state is purely a record of last cycle's grant, which
    // lets a new grant overlap the response for one access per cycle.
    always_comb begin
        state_d = IDLE;
        wr_d    = 1'b0;
        if (grant_i) begin
            state_d = RESP_I;
        end else if (grant_d) begin
            state_d = RESP_D;
            wr_d    = |data_we;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
        end
    end

    assign inst_addr_ok = grant_i;
    assign data_addr_ok = grant_d;

    assign sram_en    = grant_i | grant_d;
    assign sram_we    = grant_d ? data_we : 4'h0;
    assign sram_wdata = grant_d ? data_wdata : 32'h0;
    assign sram_addr  = grant_d ? data_addr : (grant_i ? inst_addr : 32'h0);

    assign inst_data_ok = (state_q == RESP_I);
    assign data_data_ok = (state_q == RESP_D);
    assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
    assign data_rdata   = (data_data_ok && !wr_q) ? sram_rdata : 32'h0;

endmodule
`default_nettype wire
